// File: rtl/counter_pkg.sv
// Shared encodings and widths for the three-counter access controller.
// Control-word layout, RW access modes and mode normalisation live here.
package counter_pkg;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2 * DATA_W;
  localparam int MODE_W = 3;

  typedef enum logic [1:0] {
    RW_LATCH = 2'b00,
    RW_LSB   = 2'b01,
    RW_MSB   = 2'b10,
    RW_BOTH  = 2'b11
  } rw_e;

  localparam logic [1:0] SC_READBACK = 2'b11;

  typedef struct packed {
    logic [1:0]        sc;
    rw_e               rw;
    logic [MODE_W-1:0] mode;
    logic              bcd;
  } ctrl_word_t;

  // Modes 6 and 7 alias modes 2 and 3.
  function automatic logic [MODE_W-1:0] norm_mode(input logic [MODE_W-1:0] m);
    return (m[2:1] == 2'b11) ? {1'b0, m[1:0]} : m;
  endfunction

endpackage

// File: rtl/counter_access_ctrl_if.sv
// Bus-side bundle of the access controller: decoder strobes and CPU data in,
// per-counter configuration, pulses and pointers out.
interface counter_access_ctrl_if;
  import counter_pkg::*;

  logic [3:0]        WFlag;
  logic [3:0]        RFlag;
  logic [DATA_W-1:0] DIN;
  logic [MODE_W-1:0] MODE0;
  logic [MODE_W-1:0] MODE1;
  logic [MODE_W-1:0] MODE2;
  logic [2:0]        BCD;
  logic [1:0]        RWM0;
  logic [1:0]        RWM1;
  logic [1:0]        RWM2;
  logic [2:0]        CFG_WR;
  logic [2:0]        LOAD;
  logic [CNT_W-1:0]  COUNT_VAL;
  logic [2:0]        LATCH;
  logic [2:0]        RD_HI;
  logic [2:0]        ARMED;

  modport master (
    output WFlag, RFlag, DIN,
    input  MODE0, MODE1, MODE2, BCD, RWM0, RWM1, RWM2,
    input  CFG_WR, LOAD, COUNT_VAL, LATCH, RD_HI, ARMED
  );

  modport slave (
    input  WFlag, RFlag, DIN,
    output MODE0, MODE1, MODE2, BCD, RWM0, RWM1, RWM2,
    output CFG_WR, LOAD, COUNT_VAL, LATCH, RD_HI, ARMED
  );

endinterface

// File: rtl/counter_chan_seq.sv
// Per-counter sequencer: programmed mode/RW/BCD, write byte pointer with held
// LSB, read byte pointer, and the one-cycle CFG_WR / LOAD / LATCH pulses.
module counter_chan_seq
  import counter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              latch_en,
  input  logic              wr_en,
  input  logic              rd_en,
  input  rw_e               cfg_rw,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic              cfg_bcd,
  input  logic [DATA_W-1:0] data,
  output logic [MODE_W-1:0] mode,
  output logic              bcd,
  output rw_e               rwm,
  output logic              armed,
  output logic              rd_hi,
  output logic              cfg_wr,
  output logic              load,
  output logic              latch,
  output logic [CNT_W-1:0]  count_val
);

  logic [MODE_W-1:0] mode_q, mode_d;
  logic              bcd_q, bcd_d;
  rw_e               rw_q, rw_d;
  logic              armed_q, armed_d;
  logic              wr_hi_q, wr_hi_d;
  logic [DATA_W-1:0] lsb_q, lsb_d;
  logic              rd_hi_q, rd_hi_d;
  logic              cfg_wr_q, cfg_wr_d;
  logic              load_q, load_d;
  logic              latch_q, latch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    // NOTE: every _d starts as its _q (pulses as 0) so no branch can infer a latch.
    mode_d   = mode_q;
    bcd_d    = bcd_q;
    rw_d     = rw_q;
    armed_d  = armed_q;
    wr_hi_d  = wr_hi_q;
    lsb_d    = lsb_q;
    rd_hi_d  = rd_hi_q;
    cnt_d    = cnt_q;
    cfg_wr_d = 1'b0;
    load_d   = 1'b0;
    latch_d  = 1'b0;

    if (rd_en) begin
      case (rw_q)
        RW_BOTH: rd_hi_d = ~rd_hi_q;
        RW_LSB:  rd_hi_d = 1'b0;
        RW_MSB:  rd_hi_d = 1'b1;
        default: ;
      endcase
    end

    if (cfg_en) begin
      rw_d     = cfg_rw;
      mode_d   = norm_mode(cfg_mode);
      bcd_d    = cfg_bcd;
      armed_d  = 1'b1;
      wr_hi_d  = 1'b0;
      rd_hi_d  = 1'b0;
      cfg_wr_d = 1'b1;
    end else if (latch_en) begin
      latch_d = 1'b1;
    end else if (wr_en && armed_q) begin
      case (rw_q)
        RW_LSB: begin
          load_d = 1'b1;
          cnt_d  = {{DATA_W{1'b0}}, data};
        end
        RW_MSB: begin
          load_d = 1'b1;
          cnt_d  = {data, {DATA_W{1'b0}}};
        end
        RW_BOTH: begin
          // Two-byte load: the first write only parks the LSB.
          if (!wr_hi_q) begin
            lsb_d   = data;
            wr_hi_d = 1'b1;
          end else begin
            load_d  = 1'b1;
            cnt_d   = {data, lsb_q};
            wr_hi_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      mode_q   <= '0;
      bcd_q    <= 1'b0;
      rw_q     <= RW_LATCH;
      armed_q  <= 1'b0;
      wr_hi_q  <= 1'b0;
      lsb_q    <= '0;
      rd_hi_q  <= 1'b0;
      cfg_wr_q <= 1'b0;
      load_q   <= 1'b0;
      latch_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      bcd_q    <= bcd_d;
      rw_q     <= rw_d;
      armed_q  <= armed_d;
      wr_hi_q  <= wr_hi_d;
      lsb_q    <= lsb_d;
      rd_hi_q  <= rd_hi_d;
      cfg_wr_q <= cfg_wr_d;
      load_q   <= load_d;
      latch_q  <= latch_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mode      = mode_q;
  assign bcd       = bcd_q;
  assign rwm       = rw_q;
  assign armed     = armed_q;
  assign rd_hi     = rd_hi_q;
  assign cfg_wr    = cfg_wr_q;
  assign load      = load_q;
  assign latch     = latch_q;
  assign count_val = cnt_q;

endmodule

// File: rtl/counter_access_ctrl.sv
// Access controller for three counters: detects strobe trailing edges, decodes
// control words, arbitrates simultaneous writes and drives three channel sequencers.
module counter_access_ctrl
  import counter_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  counter_access_ctrl_if.slave bus
);

  logic [DATA_W-1:0] din_q, din_d;
  logic [3:0]        whist_q, whist_d;
  logic [3:0]        wlow_q, wlow_d;
  logic [2:0]        rhist_q, rhist_d;
  logic [2:0]        rlow_q, rlow_d;

  logic [3:0]        w_done;
  logic [2:0]        r_done;
  ctrl_word_t        cw;
  logic [2:0]        cfg_en, latch_en, wr_en;
  logic              rflag_unused;

  // A strobe only counts as active if it was seen low after reset, so a
  // strobe already high when reset releases never produces an access.
  always_comb begin
    din_d   = (|bus.WFlag) ? bus.DIN : din_q;
    whist_d = bus.WFlag & (whist_q | wlow_q);
    wlow_d  = ~bus.WFlag;
    rhist_d = bus.RFlag[2:0] & (rhist_q | rlow_q);
    rlow_d  = ~bus.RFlag[2:0];
  end

  assign w_done       = whist_q & ~bus.WFlag;
  assign r_done       = rhist_q & ~bus.RFlag[2:0];
  assign cw           = ctrl_word_t'(din_q);
  assign rflag_unused = bus.RFlag[3];

  // Highest-index completed write wins; the control register outranks counters.
  always_comb begin
    cfg_en   = '0;
    latch_en = '0;
    wr_en    = '0;
    if (w_done[3]) begin
      if (cw.sc != SC_READBACK) begin
        if (cw.rw == RW_LATCH) latch_en[cw.sc] = 1'b1;
        else                   cfg_en[cw.sc]   = 1'b1;
      end
    end else if (w_done[2]) begin
      wr_en[2] = 1'b1;
    end else if (w_done[1]) begin
      wr_en[1] = 1'b1;
    end else if (w_done[0]) begin
      wr_en[0] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      din_q   <= '0;
      whist_q <= '0;
      wlow_q  <= '0;
      rhist_q <= '0;
      rlow_q  <= '0;
    end else begin
      din_q   <= din_d;
      whist_q <= whist_d;
      wlow_q  <= wlow_d;
      rhist_q <= rhist_d;
      rlow_q  <= rlow_d;
    end
  end

  logic [MODE_W-1:0] mode_arr [NUM_CH];
  rw_e               rwm_arr  [NUM_CH];
  logic [CNT_W-1:0]  cnt_arr  [NUM_CH];
  logic [2:0]        bcd_v, armed_v, rd_hi_v, cfg_wr_v, load_v, latch_v;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    counter_chan_seq u_chan (
      .clk       (CLK),
      .rst       (RST),
      .cfg_en    (cfg_en[k]),
      .latch_en  (latch_en[k]),
      .wr_en     (wr_en[k]),
      .rd_en     (r_done[k]),
      .cfg_rw    (cw.rw),
      .cfg_mode  (cw.mode),
      .cfg_bcd   (cw.bcd),
      .data      (din_q),
      .mode      (mode_arr[k]),
      .bcd       (bcd_v[k]),
      .rwm       (rwm_arr[k]),
      .armed     (armed_v[k]),
      .rd_hi     (rd_hi_v[k]),
      .cfg_wr    (cfg_wr_v[k]),
      .load      (load_v[k]),
      .latch     (latch_v[k]),
      .count_val (cnt_arr[k])
    );
  end

  // At most one channel loads per cycle, so an OR of gated counts suffices.
  always_comb begin
    bus.COUNT_VAL = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (load_v[k]) bus.COUNT_VAL = bus.COUNT_VAL | cnt_arr[k];
    end
  end

  assign bus.MODE0  = mode_arr[0];
  assign bus.MODE1  = mode_arr[1];
  assign bus.MODE2  = mode_arr[2];
  assign bus.RWM0   = rwm_arr[0];
  assign bus.RWM1   = rwm_arr[1];
  assign bus.RWM2   = rwm_arr[2];
  assign bus.BCD    = bcd_v;
  assign bus.ARMED  = armed_v;
  assign bus.RD_HI  = rd_hi_v;
  assign bus.CFG_WR = cfg_wr_v;
  assign bus.LOAD   = load_v;
  assign bus.LATCH  = latch_v;

endmodule

// File: tb/tb_counter_access_ctrl.sv
// Scoreboard bench for counter_access_ctrl: stimulus tasks push the expected
// output snapshot for each completed access, a negedge monitor pops and compares.
module tb_counter_access_ctrl;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_access_ctrl_if bus ();
  counter_access_ctrl dut (.CLK(clk), .RST(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Reference state per counter, in plain behavioural terms.
  bit [2:0] m_mode  [3];
  bit [1:0] m_rw    [3];
  bit       m_bcd   [3];
  bit       m_armed [3];
  bit       m_pend  [3];
  bit [7:0] m_lsb   [3];
  bit       m_rdhi  [3];

  bit [48:0] exp_q      [$];
  int        exp_cyc_q  [$];
  string     exp_name_q [$];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_rw[k] = 0; m_bcd[k] = 0; m_armed[k] = 0;
      m_pend[k] = 0; m_lsb[k] = 0; m_rdhi[k] = 0;
    end
  endfunction

  function automatic bit [48:0] snap(bit [2:0] cfg, bit [2:0] ld, bit [2:0] lt, bit [15:0] cv);
    return {m_mode[0], m_mode[1], m_mode[2], m_bcd[2], m_bcd[1], m_bcd[0],
            m_rw[0], m_rw[1], m_rw[2], cfg, ld, (ld != 0) ? cv : 16'h0000, lt,
            m_rdhi[2], m_rdhi[1], m_rdhi[0], m_armed[2], m_armed[1], m_armed[0]};
  endfunction

  function automatic bit [48:0] actual();
    return {bus.MODE0, bus.MODE1, bus.MODE2, bus.BCD, bus.RWM0, bus.RWM1, bus.RWM2,
            bus.CFG_WR, bus.LOAD, (bus.LOAD != 0) ? bus.COUNT_VAL : 16'h0000,
            bus.LATCH, bus.RD_HI, bus.ARMED};
  endfunction

  function automatic void push(bit [48:0] v, int at, string name);
    exp_q.push_back(v);
    exp_cyc_q.push_back(at);
    exp_name_q.push_back(name);
  endfunction

  // Apply every access that completes in one cycle, then queue the snapshot.
  function automatic void model_apply(bit [3:0] wd, bit [2:0] rd, bit [7:0] d, string name, int at);
    bit [2:0]  cfg, ld, lt;
    bit [15:0] cv;
    int        sc, h;
    bit [1:0]  rw;
    bit [2:0]  m;
    cfg = 0; ld = 0; lt = 0; cv = 0; h = -1;
    for (int k = 0; k < 3; k++)
      if (rd[k]) begin
        if (m_rw[k] == 2'b11)      m_rdhi[k] = !m_rdhi[k];
        else if (m_rw[k] == 2'b01) m_rdhi[k] = 1'b0;
        else if (m_rw[k] == 2'b10) m_rdhi[k] = 1'b1;
      end
    if (wd[3]) begin
      sc = int'(d[7:6]); rw = d[5:4]; m = d[3:1];
      if (sc != 3) begin
        if (rw == 2'b00) lt[sc] = 1'b1;
        else begin
          m_rw[sc] = rw;
          m_mode[sc] = (m >= 3'd6) ? m - 3'd4 : m;
          m_bcd[sc] = d[0];
          m_armed[sc] = 1'b1;
          m_pend[sc] = 1'b0;
          m_rdhi[sc] = 1'b0;
          cfg[sc] = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) if (wd[k]) h = k;
      if (h >= 0 && m_armed[h]) begin
        if (m_rw[h] == 2'b01) begin ld[h] = 1; cv = {8'h00, d}; end
        else if (m_rw[h] == 2'b10) begin ld[h] = 1; cv = {d, 8'h00}; end
        else if (m_rw[h] == 2'b11) begin
          if (!m_pend[h]) begin m_lsb[h] = d; m_pend[h] = 1; end
          else begin ld[h] = 1; cv = {d, m_lsb[h]}; m_pend[h] = 0; end
        end
      end
    end
    push(snap(cfg, ld, lt, cv), at, name);
  endfunction

  task automatic access(input bit [3:0] wf, input bit [2:0] rf, input bit [7:0] d, input string name);
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.WFlag = wf;
      bus.RFlag = {1'b0, rf};
      bus.DIN   = (i == n - 1) ? d : 8'($urandom);
    end
    @(posedge clk); #1;
    bus.WFlag = 4'b0000;
    bus.RFlag = 4'b0000;
    bus.DIN   = 8'($urandom);
    model_apply(wf, rf, d, name, cyc + 1);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(snap(0, 0, 0, 0), cyc, name);
    repeat (2) @(posedge clk);
  endtask

  always @(negedge clk) begin
    bit [48:0] act;
    if (mon_en) begin
      act = actual();
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL %s: expected snapshot never compared (due cycle %0d, now %0d)",
                 exp_name_q[0], exp_cyc_q[0], cyc);
        void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front()); void'(exp_name_q.pop_front());
      end
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        checks++;
        if (act !== exp_q[0]) begin
          errors++;
          $display("FAIL %s: cycle %0d got %h expected %h", exp_name_q[0], cyc, act, exp_q[0]);
        end
        void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front()); void'(exp_name_q.pop_front());
      end else begin
        checks++;
        if ({bus.CFG_WR, bus.LOAD, bus.LATCH} !== 9'b0) begin
          errors++;
          $display("FAIL idle_pulse: cycle %0d got cfg_wr/load/latch %b expected 000000000",
                   cyc, {bus.CFG_WR, bus.LOAD, bus.LATCH});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int op, a, b;
    bit [7:0] d;
    bus.WFlag = 4'b0000;
    bus.RFlag = 4'b0000;
    bus.DIN   = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    push(snap(0, 0, 0, 0), cyc, "reset_state");
    repeat (2) @(posedge clk);

    access(4'b0100, 3'b000, 8'h5A, "wr_unarmed_ch2");
    access(4'b1000, 3'b000, 8'hF0, "readback_ignored");

    access(4'b1000, 3'b000, 8'h34, "cw34_cfg0");
    access(4'b0001, 3'b000, 8'hA8, "ch0_lsb_no_load");
    access(4'b0001, 3'b000, 8'h61, "ch0_load_61a8");

    access(4'b1000, 3'b000, 8'h56, "cw56_cfg1");
    access(4'b0010, 3'b000, 8'h0F, "ch1_load_000f");
    access(4'b1000, 3'b000, 8'h9E, "cw9e_mode_alias");
    access(4'b0100, 3'b000, 8'hC3, "ch2_lsb_only");
    access(4'b0000, 3'b100, 8'h00, "ch2_read_rw01");

    for (int i = 0; i < 3; i++) access(4'b0000, 3'b001, 8'h00, "ch0_read_toggle");
    access(4'b1000, 3'b000, 8'h00, "cw00_latch0");

    access(4'b0001, 3'b000, 8'h77, "ch0_partial_lsb");
    access(4'b1000, 3'b000, 8'h30, "cw30_discard");
    access(4'b0001, 3'b000, 8'h11, "ch0_lsb_11");
    access(4'b0001, 3'b000, 8'h22, "ch0_load_2211");

    access(4'b0010, 3'b001, 8'h44, "wr1_rd0_concurrent");
    access(4'b1001, 3'b000, 8'hA4, "arb_ctrl_over_ch0");
    access(4'b0110, 3'b000, 8'h99, "arb_ch2_over_ch1");

    // Reset in the middle of a control-word strobe that stays high past release.
    @(posedge clk); #1;
    bus.WFlag = 4'b1000; bus.DIN = 8'h34;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(snap(0, 0, 0, 0), cyc, "mid_strobe_reset");
    repeat (2) @(posedge clk);
    #1 bus.WFlag = 4'b0000;
    push(snap(0, 0, 0, 0), cyc + 1, "no_action_after_reset");
    repeat (2) @(posedge clk);

    for (int i = 0; i < 220; i++) begin
      op = $urandom_range(0, 9);
      a  = $urandom_range(0, 2);
      b  = (a + $urandom_range(1, 2)) % 3;
      d  = 8'($urandom);
      case (op)
        0, 1:       access(4'b1000, 3'b000, d, "rand_ctrl");
        2, 3, 4, 5: access(4'(1 << a), 3'b000, d, "rand_write");
        6, 7:       access(4'b0000, 3'(1 << a), d, "rand_read");
        8:          access(4'(1 << a), 3'(1 << b), d, "rand_wr_rd");
        default:    access(4'($urandom_range(3, 15)), 3'b000, d, "rand_arb");
      endcase
      if (i == 110) do_reset("rand_reset");
    end

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_access_ctrl.md
COUNTER_ACCESS_CTRL -- requirements
Module: counter_access_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port WFlag, input, 4 bits: one-hot write-access level from the bus decoder; bits 0-2 select counters 0-2, bit 3 selects the control register.
REQ-004 SHALL have port RFlag, input, 4 bits: one-hot read-access level from the bus decoder; bits 0-2 select counters 0-2, bit 3 is unused.
REQ-005 SHALL have port DIN, input, 8 bits: CPU data bus, valid while a WFlag bit is high.
REQ-006 SHALL have port MODE0/MODE1/MODE2, output, 3 bits each: programmed mode per counter.
REQ-007 SHALL have port BCD, output, 3 bits: programmed BCD flag per counter.
REQ-008 SHALL have port RWM0/RWM1/RWM2, output, 2 bits each: programmed read/write access mode per counter.
REQ-009 SHALL have port CFG_WR, output, 3 bits: one-cycle pulse per counter when a mode control word is accepted.
REQ-010 SHALL have port LOAD, output, 3 bits: one-cycle pulse per counter when a complete count is assembled.
REQ-011 SHALL have port COUNT_VAL, output, 16 bits: assembled count, valid in the cycle LOAD pulses.
REQ-012 SHALL have port LATCH, output, 3 bits: one-cycle pulse per counter on a counter-latch command.
REQ-013 SHALL have port RD_HI, output, 3 bits: per counter, 1 = next read returns MSB, 0 = next read returns LSB.
REQ-014 SHALL have port ARMED, output, 3 bits: per counter, 1 once a mode control word has been accepted.

Function
REQ-015 SHALL sample DIN each cycle while any WFlag bit is high and hold the last sampled value.
REQ-016 SHALL treat an access as complete in the first cycle a flag bit is 0 after having been 1 (trailing edge); state and pulses update at the closing clock edge of that cycle (visible next cycle); pulses last exactly one cycle.
REQ-017 SHALL decode a control word (WFlag[3] trailing edge) as SC=bits[7:6], RW=bits[5:4], M=bits[3:1], BCD=bit[0].
REQ-018 SHALL ignore control words with SC=11 (read-back): no state change, no pulse.
REQ-019 SHALL, for RW=00, pulse LATCH[SC] only, leaving mode, RW, and pointers unchanged.
REQ-020 SHALL, for RW≠00, store RW, BCD and mode (M=11x stored as 01x), set ARMED[SC], reset that counter's write and read pointers to LSB, discard any partial count, and pulse CFG_WR[SC].
REQ-021 SHALL ignore counter data writes while ARMED is 0.
REQ-022 SHALL, for RW=01, pulse LOAD with COUNT_VAL={8'h00,data} on each write.
REQ-023 SHALL, for RW=10, pulse LOAD with COUNT_VAL={data,8'h00} on each write.
REQ-024 SHALL, for RW=11, hold the first write as LSB, then on the second write pulse LOAD with COUNT_VAL={MSB,LSB} and return the pointer to LSB.
REQ-025 SHALL, on an RFlag[k] trailing edge: toggle RD_HI[k] when RW=11; hold RD_HI[k]=0 when RW=01; hold RD_HI[k]=1 when RW=10.
REQ-026 SHALL, if more than one WFlag bit has a trailing edge in the same cycle, act only on the highest-index bit (control register first) and drop the rest.
REQ-027 SHALL allow a write on one counter and a read on another to complete in the same cycle, with both taking effect.

Reset
REQ-028 SHALL, in a cycle with RST high, clear all outputs, modes, pointers, ARMED, held data and flag-history registers to 0.
REQ-029 SHALL produce no action for an access whose strobe is already high when RST deasserts, until that flag next rises and falls.

Structure
REQ-030 SHALL take RW encodings, SC read-back code, and mode/data widths from the shared package counter_pkg.
REQ-031 SHALL instantiate sub-module counter_chan_seq three times, one per counter, holding that counter's mode registers and read/write pointers.

Verification
REQ-032 SHALL verify: after reset, control word 8'h34 then data writes 8'hA8, 8'h61 -> CFG_WR[0] pulse; MODE0=2, RWM0=11; one LOAD[0] pulse with COUNT_VAL=16'h61A8, occurring only after the second write.
REQ-033 SHALL verify: control word 8'h56, then write 8'h0F -> LOAD[1] pulse with COUNT_VAL=16'h000F; control word 8'h9E (M=111) -> MODE2=3.
REQ-034 SHALL verify: counter 0 at RW=11, three reads -> RD_HI[0] goes 0,1,0; control word 8'h00 -> LATCH[0] pulse with RD_HI[0] and MODE0 unchanged.
REQ-035 SHALL verify: counter 0 at RW=11, LSB write then control word 8'h30 then writes 8'h11, 8'h22 -> COUNT_VAL=16'h2211.
REQ-036 SHALL verify: data write to counter 2 before any control word -> no LOAD; control word 8'hF0 -> no change to any output.
REQ-037 SHALL verify: RST asserted mid-strobe, released with WFlag still high, then WFlag falls -> no pulse on any output.
